// File: rtl/tcdm_superbank_arbiter.sv
// Superbank front-end: arbitrates N wide DMA ports against per-bank interconnect
// requests, with a round-robin DMA pick, an IC starvation guard and a tagged read pipeline.
module tcdm_superbank_arbiter #(
  parameter int unsigned NumDmaPorts       = 2,
  parameter int unsigned BanksPerSuperbank = 4,
  parameter int unsigned AddrMemWidth      = 10,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned AmoWidth          = 4,
  parameter int unsigned MemLatency        = 1,
  parameter int unsigned MaxIcStall        = 8,
  parameter int unsigned DmaDataWidth      = BanksPerSuperbank * DataWidth,
  parameter int unsigned IdxW              = (NumDmaPorts > 1) ? $clog2(NumDmaPorts) : 1
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic [BanksPerSuperbank-1:0]                          ic_req_i,
  output logic [BanksPerSuperbank-1:0]                          ic_gnt_o,
  input  logic [BanksPerSuperbank-1:0][AddrMemWidth-1:0]        ic_add_i,
  input  logic [BanksPerSuperbank-1:0][AmoWidth-1:0]            ic_amo_i,
  input  logic [BanksPerSuperbank-1:0]                          ic_wen_i,
  input  logic [BanksPerSuperbank-1:0][DataWidth-1:0]           ic_wdata_i,
  input  logic [BanksPerSuperbank-1:0][DataWidth/8-1:0]         ic_be_i,
  output logic [BanksPerSuperbank-1:0][DataWidth-1:0]           ic_rdata_o,
  output logic [BanksPerSuperbank-1:0]                          ic_rvalid_o,
  input  logic [NumDmaPorts-1:0]                                dma_req_i,
  output logic [NumDmaPorts-1:0]                                dma_gnt_o,
  input  logic [NumDmaPorts-1:0][AddrMemWidth-1:0]              dma_add_i,
  input  logic [NumDmaPorts-1:0][AmoWidth-1:0]                  dma_amo_i,
  input  logic [NumDmaPorts-1:0]                                dma_wen_i,
  input  logic [NumDmaPorts-1:0][DmaDataWidth-1:0]              dma_wdata_i,
  input  logic [NumDmaPorts-1:0][DmaDataWidth/8-1:0]            dma_be_i,
  output logic [NumDmaPorts-1:0][DmaDataWidth-1:0]              dma_rdata_o,
  output logic [NumDmaPorts-1:0]                                dma_rvalid_o,
  output logic [BanksPerSuperbank-1:0]                          amo_req_o,
  input  logic [BanksPerSuperbank-1:0]                          amo_gnt_i,
  output logic [BanksPerSuperbank-1:0][AddrMemWidth-1:0]        amo_add_o,
  output logic [BanksPerSuperbank-1:0][AmoWidth-1:0]            amo_amo_o,
  output logic [BanksPerSuperbank-1:0]                          amo_wen_o,
  output logic [BanksPerSuperbank-1:0][DataWidth-1:0]           amo_wdata_o,
  output logic [BanksPerSuperbank-1:0][DataWidth/8-1:0]         amo_be_o,
  input  logic [BanksPerSuperbank-1:0][DataWidth-1:0]           amo_rdata_i
);

  localparam int unsigned StallW = (MaxIcStall > 0) ? $clog2(MaxIcStall + 1) : 1;
  localparam int unsigned Head   = MemLatency - 1;
  localparam int unsigned BeW    = DataWidth / 8;

  // Handshake: a transfer happens in the cycle where req and gnt are both high; gnt is a
  // same-cycle combinational answer, and a requester keeps req and payload stable until granted.

  logic [IdxW-1:0]   rr_q;
  logic [StallW-1:0] stall_q;
  logic [IdxW-1:0]   win;
  logic              found;
  logic              guard_fire;
  logic              dma_own;
  logic              dma_acc;

  logic [MemLatency-1:0]                        pipe_dma_v;
  logic [MemLatency-1:0][IdxW-1:0]              pipe_idx;
  logic [MemLatency-1:0][BanksPerSuperbank-1:0] pipe_ic_v;

  // Cyclic search from rr_q: first pass covers indices >= rr_q, second pass wraps around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int j = 0; j < NumDmaPorts; j++) begin
      if (!found && dma_req_i[j] && (IdxW'(j) >= rr_q)) begin
        found = 1'b1;
        win   = IdxW'(j);
      end
    end
    for (int j = 0; j < NumDmaPorts; j++) begin
      if (!found && dma_req_i[j]) begin
        found = 1'b1;
        win   = IdxW'(j);
      end
    end
  end

  assign guard_fire = (MaxIcStall != 0) && (stall_q == StallW'(MaxIcStall));
  assign dma_own    = found && !guard_fire;
  // A wide beat needs every bank at once; a partial grant is simply retried.
  assign dma_acc    = dma_own && (&amo_gnt_i);

  always_comb begin
    amo_req_o   = ic_req_i;
    amo_add_o   = ic_add_i;
    amo_amo_o   = ic_amo_i;
    amo_wen_o   = ic_wen_i;
    amo_wdata_o = ic_wdata_i;
    amo_be_o    = ic_be_i;
    ic_gnt_o    = amo_gnt_i & ic_req_i;
    dma_gnt_o   = '0;
    if (dma_own) begin
      amo_req_o = '1;
      ic_gnt_o  = '0;
      amo_wen_o = {BanksPerSuperbank{dma_wen_i[win]}};
      for (int b = 0; b < BanksPerSuperbank; b++) begin
        amo_add_o[b]   = dma_add_i[win];
        amo_amo_o[b]   = dma_amo_i[win];
        amo_wdata_o[b] = dma_wdata_i[win][b*DataWidth +: DataWidth];
        amo_be_o[b]    = dma_be_i[win][b*BeW +: BeW];
      end
      dma_gnt_o[win] = dma_acc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      stall_q <= '0;
    end else begin
      if (dma_acc) begin
        rr_q <= (win == IdxW'(NumDmaPorts - 1)) ? '0 : win + 1'b1;
      end
      if (dma_own && (|ic_req_i)) begin
        if (!guard_fire) stall_q <= stall_q + 1'b1;
      end else begin
        stall_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_dma_v <= '0;
      pipe_idx   <= '0;
      pipe_ic_v  <= '0;
    end else begin
      pipe_dma_v[0] <= dma_acc && !dma_wen_i[win];
      pipe_idx[0]   <= win;
      pipe_ic_v[0]  <= dma_own ? '0 : (ic_req_i & amo_gnt_i & ~ic_wen_i);
      for (int s = 1; s < MemLatency; s++) begin
        pipe_dma_v[s] <= pipe_dma_v[s-1];
        pipe_idx[s]   <= pipe_idx[s-1];
        pipe_ic_v[s]  <= pipe_ic_v[s-1];
      end
    end
  end

  // Bank rdata is shared; the head tag decides who sees it.
  always_comb begin
    dma_rdata_o  = '0;
    dma_rvalid_o = '0;
    ic_rdata_o   = amo_rdata_i;
    ic_rvalid_o  = pipe_ic_v[Head];
    if (pipe_dma_v[Head]) begin
      dma_rdata_o[pipe_idx[Head]]  = amo_rdata_i;
      dma_rvalid_o[pipe_idx[Head]] = 1'b1;
      ic_rdata_o                   = '0;
      ic_rvalid_o                  = '0;
    end
  end

endmodule

// File: tb/tb_tcdm_superbank_arbiter.sv
// Bench for tcdm_superbank_arbiter: directed scenarios then protocol-respecting random
// traffic, all checked every cycle against a cycle-indexed behavioural model.
module tb_tcdm_superbank_arbiter;

  localparam int N    = 3;
  localparam int B    = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int AMW  = 4;
  localparam int ML   = 3;
  localparam int MAXS = 3;
  localparam int DDW  = B * DW;
  localparam int BEW  = DW / 8;
  localparam int DBEW = DDW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [B-1:0]              ic_req, ic_gnt, ic_wen, ic_rvalid;
  logic [B-1:0][AW-1:0]      ic_add;
  logic [B-1:0][AMW-1:0]     ic_amo;
  logic [B-1:0][DW-1:0]      ic_wdata, ic_rdata;
  logic [B-1:0][BEW-1:0]     ic_be;
  logic [N-1:0]              dma_req, dma_gnt, dma_wen, dma_rvalid;
  logic [N-1:0][AW-1:0]      dma_add;
  logic [N-1:0][AMW-1:0]     dma_amo;
  logic [N-1:0][DDW-1:0]     dma_wdata, dma_rdata;
  logic [N-1:0][DBEW-1:0]    dma_be;
  logic [B-1:0]              amo_req, amo_gnt, amo_wen;
  logic [B-1:0][AW-1:0]      amo_add;
  logic [B-1:0][AMW-1:0]     amo_amo;
  logic [B-1:0][DW-1:0]      amo_wdata, amo_rdata;
  logic [B-1:0][BEW-1:0]     amo_be;

  tcdm_superbank_arbiter #(
    .NumDmaPorts(N), .BanksPerSuperbank(B), .AddrMemWidth(AW), .DataWidth(DW),
    .AmoWidth(AMW), .MemLatency(ML), .MaxIcStall(MAXS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ic_req_i(ic_req), .ic_gnt_o(ic_gnt), .ic_add_i(ic_add), .ic_amo_i(ic_amo),
    .ic_wen_i(ic_wen), .ic_wdata_i(ic_wdata), .ic_be_i(ic_be),
    .ic_rdata_o(ic_rdata), .ic_rvalid_o(ic_rvalid),
    .dma_req_i(dma_req), .dma_gnt_o(dma_gnt), .dma_add_i(dma_add), .dma_amo_i(dma_amo),
    .dma_wen_i(dma_wen), .dma_wdata_i(dma_wdata), .dma_be_i(dma_be),
    .dma_rdata_o(dma_rdata), .dma_rvalid_o(dma_rvalid),
    .amo_req_o(amo_req), .amo_gnt_i(amo_gnt), .amo_add_o(amo_add), .amo_amo_o(amo_amo),
    .amo_wen_o(amo_wen), .amo_wdata_o(amo_wdata), .amo_be_o(amo_be), .amo_rdata_i(amo_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Model state: round-robin pointer, stall count, and expected responses keyed by cycle.
  int rr, stall, cyc;
  int exp_dma_at[int];
  logic [B-1:0] exp_ic_at[int];
  logic [N-1:0] last_dma_gnt, obs_dma_gnt, obs_dma_rvalid;
  logic [B-1:0] last_ic_gnt, obs_ic_gnt, obs_ic_rvalid;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_dma_at.delete();
    exp_ic_at.delete();
    rr = 0;
    stall = 0;
  endtask

  task automatic rand_rdata();
    for (int b = 0; b < B; b++) amo_rdata[b] = $urandom;
  endtask

  task automatic set_idle();
    dma_req = '0;
    ic_req  = '0;
    amo_gnt = '1;
  endtask

  task automatic set_dma(input int p, input logic wen);
    dma_add[p]   = AW'($urandom);
    dma_amo[p]   = AMW'($urandom);
    dma_wen[p]   = wen;
    dma_wdata[p] = {$urandom, $urandom, $urandom, $urandom};
    dma_be[p]    = DBEW'($urandom);
  endtask

  task automatic set_ic(input int b, input logic wen);
    ic_add[b]   = AW'($urandom);
    ic_amo[b]   = AMW'($urandom);
    ic_wen[b]   = wen;
    ic_wdata[b] = $urandom;
    ic_be[b]    = BEW'($urandom);
  endtask

  // One clock cycle: check all outputs at the falling edge, advance the model, then move
  // to just after the next rising edge where the caller drives new inputs.
  task automatic step();
    logic [N-1:0]           e_dgnt, e_drv;
    logic [B-1:0]           e_ignt, e_req, e_wen, e_irv, rd_mask;
    logic [B-1:0][AW-1:0]   e_add;
    logic [B-1:0][AMW-1:0]  e_amo;
    logic [DDW-1:0]         e_wdata;
    logic [DDW/8-1:0]       e_be;
    logic [N-1:0][DDW-1:0]  e_drd;
    logic [B-1:0][DW-1:0]   e_ird;
    logic found, own;
    int w;
    @(negedge clk);
    found = 1'b0;
    w = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && dma_req[(rr + k) % N]) begin
        found = 1'b1;
        w = (rr + k) % N;
      end
    end
    own = found && !(MAXS > 0 && stall == MAXS);
    e_dgnt = '0;
    if (own && (&amo_gnt)) e_dgnt[w] = 1'b1;
    e_ignt = own ? '0 : (ic_req & amo_gnt);
    if (own) begin
      e_req = '1;
      e_wen = {B{dma_wen[w]}};
      for (int b = 0; b < B; b++) begin
        e_add[b] = dma_add[w];
        e_amo[b] = dma_amo[w];
      end
      e_wdata = dma_wdata[w];
      e_be    = dma_be[w];
    end else begin
      e_req   = ic_req;
      e_wen   = ic_wen;
      e_add   = ic_add;
      e_amo   = ic_amo;
      e_wdata = ic_wdata;
      e_be    = ic_be;
    end
    e_drv = '0;
    e_drd = '0;
    e_irv = '0;
    e_ird = amo_rdata;
    if (exp_dma_at.exists(cyc)) begin
      e_drv[exp_dma_at[cyc]] = 1'b1;
      e_drd[exp_dma_at[cyc]] = amo_rdata;
      e_ird = '0;
    end else if (exp_ic_at.exists(cyc)) begin
      e_irv = exp_ic_at[cyc];
    end
    chk("ic_gnt", ic_gnt, e_ignt);
    chk("dma_gnt", dma_gnt, e_dgnt);
    chk("amo_req", amo_req, e_req);
    chk("amo_add", amo_add, e_add);
    chk("amo_amo", amo_amo, e_amo);
    chk("amo_wen", amo_wen, e_wen);
    chk("amo_wdata", amo_wdata, e_wdata);
    chk("amo_be", amo_be, e_be);
    chk("ic_rvalid", ic_rvalid, e_irv);
    chk("ic_rdata", ic_rdata, e_ird);
    chk("dma_rvalid", dma_rvalid, e_drv);
    chk("dma_rdata", dma_rdata, e_drd);
    obs_dma_gnt    = dma_gnt;
    obs_ic_gnt     = ic_gnt;
    obs_dma_rvalid = dma_rvalid;
    obs_ic_rvalid  = ic_rvalid;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (own && (&amo_gnt)) begin
        if (!dma_wen[w]) exp_dma_at[cyc + ML] = w;
        rr = (w + 1) % N;
      end
      rd_mask = ic_req & amo_gnt & ~ic_wen;
      if (!own && (|rd_mask)) exp_ic_at[cyc + ML] = rd_mask;
      if (own && (|ic_req)) stall = (stall < MAXS) ? stall + 1 : MAXS;
      else stall = 0;
    end
    last_dma_gnt = e_dgnt;
    last_ic_gnt  = e_ignt;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    for (int p = 0; p < N; p++) begin
      if (!dma_req[p] || last_dma_gnt[p]) begin
        dma_req[p] = ($urandom_range(0, 2) != 0);
        set_dma(p, 1'($urandom));
      end
    end
    for (int b = 0; b < B; b++) begin
      if (!ic_req[b] || last_ic_gnt[b]) begin
        ic_req[b] = ($urandom_range(0, 1) != 0);
        set_ic(b, 1'($urandom));
      end
    end
    amo_gnt = ($urandom_range(0, 3) == 0) ? B'($urandom) : '1;
    rand_rdata();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    last_dma_gnt = '0;
    last_ic_gnt  = '0;
    set_idle();
    for (int p = 0; p < N; p++) set_dma(p, 1'b0);
    for (int b = 0; b < B; b++) set_ic(b, 1'b0);
    rand_rdata();
    @(posedge clk);
    #1;

    // Reset state: no responses, IC rdata passthrough.
    repeat (2) begin
      rand_rdata();
      step();
    end
    rst_n = 1'b1;

    // Round-robin: all ports read with full grants.
    for (int p = 0; p < N; p++) set_dma(p, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dma_req = '1;
      rand_rdata();
      step();
      chk("rr_order", obs_dma_gnt, 1 << (i % N));
    end
    set_idle();
    for (int i = 0; i < ML + 1; i++) begin
      rand_rdata();
      step();
    end

    // Partial grant: port 0 read, banks stall twice, then all grant.
    set_dma(0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      dma_req = 3'b001;
      amo_gnt = (i < 2) ? 4'b1011 : 4'b1111;
      rand_rdata();
      step();
      chk("partial_gnt", obs_dma_gnt, (i < 2) ? 3'b000 : 3'b001);
    end
    set_idle();
    for (int i = 0; i < ML + 1; i++) begin
      rand_rdata();
      step();
    end

    // Starvation guard: port 0 streams reads, IC bank 2 load waits.
    set_ic(2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      dma_req = (i < 6) ? 3'b001 : 3'b000;
      ic_req  = (i <= 3) ? 4'b0100 : 4'b0000;
      if (i < 6) set_dma(0, 1'b0);
      rand_rdata();
      step();
      chk("guard_dma_gnt", obs_dma_gnt, (i < 6 && i != 3) ? 3'b001 : 3'b000);
      chk("guard_ic_gnt", obs_ic_gnt, (i == 3) ? 4'b0100 : 4'b0000);
      chk("guard_ic_rvalid", obs_ic_rvalid, (i == 3 + ML) ? 4'b0100 : 4'b0000);
    end

    // Tag routing: DMA1 read, IC bank 0 read, DMA0 write.
    for (int i = 0; i < 3 + ML; i++) begin
      set_idle();
      if (i == 0) begin dma_req = 3'b010; set_dma(1, 1'b0); end
      if (i == 1) begin ic_req = 4'b0001; set_ic(0, 1'b0); end
      if (i == 2) begin dma_req = 3'b001; set_dma(0, 1'b1); end
      rand_rdata();
      step();
      chk("route_dma_rvalid", obs_dma_rvalid, (i == ML) ? 3'b010 : 3'b000);
      chk("route_ic_rvalid", obs_ic_rvalid, (i == ML + 1) ? 4'b0001 : 4'b0000);
    end

    // Reset mid-flight with reads in the pipeline; rr is left non-zero.
    for (int i = 0; i < 3; i++) begin
      set_idle();
      dma_req = (i == 1) ? 3'b010 : 3'b001;
      set_dma((i == 1) ? 1 : 0, 1'b0);
      rand_rdata();
      step();
    end
    set_idle();
    rand_rdata();
    chk("pre_rst_rvalid", dma_rvalid, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dma_rvalid", dma_rvalid, 3'b000);
    chk("rst_ic_rvalid", ic_rvalid, 4'b0000);
    chk("rst_dma_rdata", dma_rdata, '0);
    model_reset();
    repeat (2) begin
      rand_rdata();
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < ML + 1; i++) begin
      rand_rdata();
      step();
      chk("post_rst_rvalid", {obs_dma_rvalid, obs_ic_rvalid}, '0);
    end
    dma_req = '1;
    for (int p = 0; p < N; p++) set_dma(p, 1'b0);
    rand_rdata();
    step();
    chk("post_rst_rr", obs_dma_gnt, 3'b001);
    set_idle();
    for (int i = 0; i < ML + 1; i++) begin
      rand_rdata();
      step();
    end

    // Random traffic with requesters holding until granted.
    last_dma_gnt = '0;
    last_ic_gnt  = '0;
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end
    set_idle();
    for (int i = 0; i < ML + 1; i++) begin
      rand_rdata();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_superbank_arbiter.md
# tcdm_superbank_arbiter

Parametrised successor to the two-port superbank mux. It sits between the TCDM interconnect and one superbank of `BanksPerSuperbank` banks (via their AMO units), and arbitrates `NumDmaPorts` wide DMA ports against the per-bank interconnect requests. Arbitration is internal: DMA round-robin plus a bounded interconnect-starvation guard. It replaces the external select lines and the fixed 1-cycle response path with a tagged response pipeline of configurable depth, which returns read data and valid only to the requester that issued the read.

## Interface
- `NumDmaPorts`, default 2: number of DMA ports, ≥1.
- `BanksPerSuperbank`, default 4: banks per superbank, ≥1.
- `AddrMemWidth`, default 10: bank word address width.
- `DataWidth`, default 32: bank data width.
- `AmoWidth`, default 4: AMO opcode width.
- `MemLatency`, default 1: request-to-rdata cycles of the banks, ≥1.
- `MaxIcStall`, default 8: max consecutive cycles the interconnect may be blocked; 0 means no guard (DMA always wins).
- Derived: `DmaDataWidth = BanksPerSuperbank*DataWidth`; `IdxW = max(1,$clog2(NumDmaPorts))`.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `rst_ni` in 1: async active-low reset.
- `ic_req_i` in [B]: per-bank interconnect request.
- `ic_gnt_o` out [B]: per-bank interconnect grant.
- `ic_add_i` in [B][AddrMemWidth]: interconnect address.
- `ic_amo_i` in [B][AmoWidth]: interconnect AMO opcode.
- `ic_wen_i` in [B]: 1 = store, 0 = load.
- `ic_wdata_i` in [B][DataWidth]: interconnect write data.
- `ic_be_i` in [B][DataWidth/8]: interconnect byte enable.
- `ic_rdata_o` out [B][DataWidth]: interconnect read data.
- `ic_rvalid_o` out [B]: interconnect read data valid.
- `dma_req_i` in [N]: DMA request.
- `dma_gnt_o` out [N]: DMA grant.
- `dma_add_i` in [N][AddrMemWidth]: DMA address.
- `dma_amo_i` in [N][AmoWidth]: DMA AMO opcode.
- `dma_wen_i` in [N]: 1 = store, 0 = load.
- `dma_wdata_i` in [N][DmaDataWidth]: DMA write data.
- `dma_be_i` in [N][DmaDataWidth/8]: DMA byte enable.
- `dma_rdata_o` out [N][DmaDataWidth]: DMA read data.
- `dma_rvalid_o` out [N]: DMA read data valid.
- `amo_req_o` out [B]: bank request.
- `amo_gnt_i` in [B]: bank grant.
- `amo_add_o`, `amo_amo_o`, `amo_wen_o`, `amo_wdata_o`, `amo_be_o` out, per bank: bank request payload.
- `amo_rdata_i` in [B][DataWidth]: bank read data.

## Operation
- **Owner per cycle.**
  - DMA owns when `|dma_req_i` and the starvation guard is not firing.
  - Otherwise the interconnect owns.
- **IC owns.**
  - `amo_*_o` = `ic_*_i` passthrough; `ic_gnt_o = amo_gnt_i & ic_req_i`.
  - `dma_gnt_o = 0`.
- **DMA owns.**
  - Winner `w` = first requesting index at or after `rr_q`, searching cyclically.
  - `amo_req_o` = all ones.
  - Address, AMO and wen replicated to every bank.
  - Bank `b` takes slice `b` of `dma_wdata_i[w]` and `dma_be_i[w]`.
  - `ic_gnt_o = 0`.
  - `dma_gnt_o[w] = &amo_gnt_i`; all other bits 0.
- **Handshake.**
  - A DMA beat is accepted only when all banks grant in the same cycle.
  - A partial grant is ignored, and the request is re-presented unchanged.
  - On acceptance, `rr_q <= (w+1) mod N`; otherwise `rr_q` holds.
  - A requester may drop `req` only after its grant.
- **Starvation guard** (`MaxIcStall > 0`).
  - `stall_q` increments (saturating at `MaxIcStall`) in each cycle where DMA owns and `|ic_req_i`.
  - `stall_q` clears when IC owns, or when no IC request is pending.
  - The guard fires when `stall_q == MaxIcStall`: the interconnect owns that cycle regardless of DMA requests.
- **Response pipeline.**
  - `MemLatency` stages. Each stage holds:
    - `dma_v`: 1 if a DMA read was accepted.
    - `idx`: the winner index.
    - `ic_v[B]`: `ic_req_i & amo_gnt_i & ~ic_wen_i` when IC owned.
  - Stores never produce rvalid.
- **Response output at the pipeline head.**
  - If `dma_v`: `dma_rdata_o[idx] = {amo_rdata_i[B-1..0]}` and `dma_rvalid_o[idx] = 1`; other DMA ports read 0; `ic_rdata_o = 0`, `ic_rvalid_o = 0`.
  - Else: `ic_rdata_o = amo_rdata_i`, `ic_rvalid_o = ic_v`, and all DMA rdata/rvalid = 0.
- **AMO on the DMA path.** The opcode is forwarded to all banks; the result is returned like a load.

## Timing
- **Request path is combinational:** grants are valid in the same cycle as the request.
- **Read response** appears exactly `MemLatency` cycles after acceptance. Back-to-back accepted reads produce back-to-back responses; there are no bubbles and no reordering.
- **Reset** (`rst_ni` low, async):
  - `rr_q = 0`, `stall_q = 0`, all pipeline valids = 0.
  - Hence `dma_rvalid_o = 0`, `ic_rvalid_o = 0`, `dma_rdata_o = 0`, `ic_rdata_o = amo_rdata_i`.
  - Grants follow the combinational rules from the first cycle.
  - In-flight responses are discarded, and none reappear after release.
- **Simultaneous events.**
  - Guard firing and DMA requests in the same cycle: IC wins.
  - DMA accepted and `rr_q` wrapping from N-1: `rr_q` goes to 0.
- **N = 1:** the round-robin is degenerate; `idx` is constant 0.

## Test plan
- **Round-robin.**
  - Stimulus: N=2, B=4, `amo_gnt_i` = 1111, both DMA ports request reads for 4 cycles.
  - Required: grants alternate 0, 1, 0, 1. Each `dma_rvalid_o[i]` fires 1 cycle (`MemLatency`=1) after its grant, carrying a 128-bit rdata concatenation with bank 0 in the low bits.
- **Partial grant.**
  - Stimulus: DMA 0 read, `amo_gnt_i` = 1011 for 2 cycles, then 1111.
  - Required: `dma_gnt_o` = 00, 00, 01. `rr_q` unchanged until the third cycle. Exactly one rvalid.
- **Starvation guard.**
  - Stimulus: `MaxIcStall`=3, DMA 0 continuous, IC bank 2 load pending.
  - Required: DMA granted cycles 0–2, `ic_gnt_o[2]` = 1 in cycle 3, DMA resumes in cycle 4. `ic_rvalid_o[2]` appears 1 cycle later.
- **Latency and tag routing.**
  - Stimulus: `MemLatency`=3, alternating DMA 1 read / IC bank 0 read / DMA 0 write.
  - Required: the rvalids appear 3 cycles later in order DMA1, IC0. No response for the write, and no cross-port leakage.
- **Reset mid-flight.**
  - Stimulus: assert `rst_ni` low while 2 reads are in the pipeline.
  - Required: all rvalids drop immediately, none after release, and `rr_q` = 0 on the first post-reset grant.
